// File: rtl/multi_sonar_alarm.sv
// multi_sonar_alarm: round-robin HC-SR04 ranging over CHANNELS sensors,
// echo width to whole centimetres, per-channel debounced proximity alarm.
module multi_sonar_alarm #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned DIST_W      = 9,
    parameter int unsigned TRIG_CYC    = 500,
    parameter int unsigned CYC_PER_CM  = 2900,
    parameter int unsigned TIMEOUT_CYC = 1500000,
    parameter int unsigned GAP_CYC     = 3000000,
    parameter int unsigned THRESH      = 50,
    parameter int unsigned HYST        = 5,
    parameter int unsigned CONFIRM     = 3
) (
    input  logic                                            CLK,
    input  logic                                            RST,
    input  logic                                            Enable,
    input  logic [CHANNELS-1:0]                             Echo,
    output logic [CHANNELS-1:0]                             Trigger,
    output logic [CHANNELS*DIST_W-1:0]                      Distance,
    output logic                                            Sample_Valid,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] Sample_Chan,
    output logic [CHANNELS-1:0]                             No_Echo,
    output logic [CHANNELS-1:0]                             Alarm
);

    localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned CNT_MAX = (TRIG_CYC > TIMEOUT_CYC)
                                      ? ((TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC)
                                      : ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SUB_W   = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;
    localparam int unsigned CF_W    = $clog2(CONFIRM + 1);
    localparam logic [DIST_W-1:0] DIST_MAX = '1;

    typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, GAP} state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [SUB_W-1:0]    sub;
    logic [DIST_W-1:0]   cm;
    logic [CH_W-1:0]     ch;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic                echo_s;
    logic [CHANNELS-1:0] trig_c;
    logic                done_c;
    logic                tout_c;
    logic [DIST_W-1:0]   dist_c;
    logic                near_c;
    logic                far_c;
    logic [CF_W-1:0]     cur_near;
    logic [CF_W-1:0]     cur_far;
    logic [CF_W-1:0]     near_nx;
    logic [CF_W-1:0]     far_nx;
    logic [CF_W-1:0]     near_cnt [CHANNELS];
    logic [CF_W-1:0]     far_cnt  [CHANNELS];

    // Two-flop synchroniser on every echo line
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Echo;
            sync2 <= sync1;
        end
    end

    // Select the synchronised echo of the active channel
    always_comb begin
        echo_s = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == CH_W'(i)) echo_s = sync2[i];
        end
    end

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Enable) state_next = TRIG;
            TRIG: if (cnt == CNT_W'(TRIG_CYC - 1)) state_next = WAIT;
            WAIT: begin
                if (echo_s)                                state_next = MEAS;
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1))   state_next = GAP;
            end
            MEAS: begin
                if (!echo_s)                               state_next = GAP;
                else if (cnt == CNT_W'(TIMEOUT_CYC - 1))   state_next = GAP;
            end
            GAP:  if (cnt == CNT_W'(GAP_CYC - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: trigger decode and sample-finish strobes (timeout when echo never fell)
    always_comb begin
        trig_c = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            trig_c[i] = (state_next == TRIG) && (ch == CH_W'(i));
        end
        done_c = (state != GAP) && (state_next == GAP);
        tout_c = done_c && ((state == WAIT) || echo_s);
    end

    // Per-state cycle counter, cleared on every state change
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                      cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (state != IDLE)       cnt <= cnt + CNT_W'(1);
    end

    // Echo-width to centimetre conversion; the WAIT cycle that sees the echo counts too
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sub <= '0;
            cm  <= '0;
        end else if (state == TRIG) begin
            sub <= '0;
            cm  <= '0;
        end else if (echo_s && ((state == WAIT) || (state == MEAS))) begin
            if (sub == SUB_W'(CYC_PER_CM - 1)) begin
                sub <= '0;
                if (cm != DIST_MAX) cm <= cm + DIST_W'(1);
            end else begin
                sub <= sub + SUB_W'(1);
            end
        end
    end

    // Round-robin channel pointer, advanced when the gap expires
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ch <= '0;
        end else if ((state == GAP) && (state_next == IDLE)) begin
            if (ch == CH_W'(CHANNELS - 1)) ch <= '0;
            else                           ch <= ch + CH_W'(1);
        end
    end

    // Sample classification and next debouncer counts for the active channel
    always_comb begin
        cur_near = '0;
        cur_far  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == CH_W'(i)) begin
                cur_near = near_cnt[i];
                cur_far  = far_cnt[i];
            end
        end
        dist_c  = tout_c ? DIST_MAX : cm;
        near_c  = !tout_c && (32'(dist_c) < THRESH);
        far_c   = tout_c || (32'(dist_c) >= (THRESH + HYST));
        near_nx = near_c ? ((cur_near == CF_W'(CONFIRM)) ? cur_near : cur_near + CF_W'(1)) : '0;
        far_nx  = far_c  ? ((cur_far  == CF_W'(CONFIRM)) ? cur_far  : cur_far  + CF_W'(1)) : '0;
    end

    // Registered outputs: trigger, sample write-back and alarm debouncers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Trigger      <= '0;
            Distance     <= '0;
            Sample_Valid <= 1'b0;
            Sample_Chan  <= '0;
            No_Echo      <= '0;
            Alarm        <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                near_cnt[i] <= '0;
                far_cnt[i]  <= '0;
            end
        end else begin
            Trigger      <= trig_c;
            Sample_Valid <= done_c;
            if (done_c) begin
                Sample_Chan <= ch;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (ch == CH_W'(i)) begin
                        Distance[i*DIST_W +: DIST_W] <= dist_c;
                        No_Echo[i]  <= tout_c;
                        near_cnt[i] <= near_nx;
                        far_cnt[i]  <= far_nx;
                        if (near_nx == CF_W'(CONFIRM))     Alarm[i] <= 1'b1;
                        else if (far_nx == CF_W'(CONFIRM)) Alarm[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
